// File: rtl/renkon_pkg.sv
// Shared definitions for the renkon pooling path: pixel width, FSM states
// and a signed max helper.
package renkon_pkg;

  localparam int DWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed maximum; on a tie either operand is the same value.
  function automatic logic signed [DWIDTH-1:0] smax(
    input logic signed [DWIDTH-1:0] a,
    input logic signed [DWIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/renkon_pool_if.sv
// Pixel stream and frame-control bundle for renkon_pool.
// Optional feature macro: RENKON_POOL_BYPASS_EN (adds the bypass request bit).
interface renkon_pool_if
  import renkon_pkg::*;
#(
  parameter int SIZEW = 6
);
  logic                     req;
  logic [SIZEW-1:0]         img_w;
  logic [SIZEW-1:0]         img_h;
  logic                     in_valid;
  logic signed [DWIDTH-1:0] pixel_in;
  logic                     out_valid;
  logic signed [DWIDTH-1:0] pixel_out;
  logic                     busy;
  logic                     done;
`ifdef RENKON_POOL_BYPASS_EN
  logic                     bypass;
`endif

  // Upstream side: issues frames and pixels, observes pooled results.
  modport master (
    output req, img_w, img_h, in_valid, pixel_in,
`ifdef RENKON_POOL_BYPASS_EN
    output bypass,
`endif
    input  out_valid, pixel_out, busy, done
  );

  // Pooling stage side.
  modport slave (
    input  req, img_w, img_h, in_valid, pixel_in,
`ifdef RENKON_POOL_BYPASS_EN
    input  bypass,
`endif
    output out_valid, pixel_out, busy, done
  );
endinterface

// File: rtl/renkon_pool_linebuf.sv
// Half-width line buffer: holds the horizontal pair maxima of an even row
// until the matching odd row arrives. Contents are not reset.
module renkon_pool_linebuf #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata
);

  logic signed [DW-1:0] mem_q [DEPTH];

  // Single write port, written on even rows.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Combinational read, used on odd rows in the same cycle as the 4th pixel.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/renkon_pool.sv
// 2x2 stride-2 signed max-pooling stage over a raster pixel stream.
// Optional feature macro: RENKON_POOL_BYPASS_EN (pass-through mode latched on req).
module renkon_pool
  import renkon_pkg::*;
#(
  parameter int MAXW  = 32,
  parameter int SIZEW = 6
) (
  input  logic          clk,
  input  logic          xrst,
  renkon_pool_if.slave  bus
);

  localparam int DEPTH = MAXW / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                   state_q, state_d;
  logic [SIZEW-1:0]         col_q, col_d;
  logic [SIZEW-1:0]         row_q, row_d;
  logic [SIZEW-1:0]         w_q, w_d;
  logic [SIZEW-1:0]         h_q, h_d;
  logic signed [DWIDTH-1:0] hold_q, hold_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DWIDTH-1:0] pixel_out_q, pixel_out_d;
  logic                     done_q, done_d;
  logic                     bypass_q, bypass_d;

  logic                     lb_we;
  logic [AW-1:0]            lb_addr;
  logic signed [DWIDTH-1:0] lb_rdata;
  logic signed [DWIDTH-1:0] pair_max;

  // Pair index of the current column; odd columns close a horizontal pair.
  assign lb_addr  = col_q[AW:1];
  assign pair_max = smax(hold_q, bus.pixel_in);

  renkon_pool_linebuf #(
    .DW    (DWIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // Next-state, counter and pooling datapath decisions.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    w_d         = w_q;
    h_d         = h_q;
    hold_d      = hold_q;
    out_valid_d = 1'b0;
    pixel_out_d = pixel_out_q;
    done_d      = 1'b0;
    bypass_d    = bypass_q;
    lb_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = RUN;
          w_d     = bus.img_w;
          h_d     = bus.img_h;
          col_d   = '0;
          row_d   = '0;
`ifdef RENKON_POOL_BYPASS_EN
          bypass_d = bus.bypass;
`else
          bypass_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          if (bypass_q) begin
            out_valid_d = 1'b1;
            pixel_out_d = bus.pixel_in;
          end else if (!col_q[0]) begin
            hold_d = bus.pixel_in;
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            pixel_out_d = smax(lb_rdata, pair_max);
          end
          // Trailing odd column/row pixels are counted but never close a window.
          if (col_q == w_q - SIZEW'(1)) begin
            col_d = '0;
            if (row_q == h_q - SIZEW'(1)) begin
              row_d   = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + SIZEW'(1);
            end
          end else begin
            col_d = col_q + SIZEW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      w_q         <= '0;
      h_q         <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      pixel_out_q <= '0;
      done_q      <= 1'b0;
      bypass_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      w_q         <= w_d;
      h_q         <= h_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      pixel_out_q <= pixel_out_d;
      done_q      <= done_d;
      bypass_q    <= bypass_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pixel_out = pixel_out_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
